// File: rtl/priority_encoder_rr_if.sv
// rtl/priority_encoder_rr_if.sv - request/result bundle for the registered priority encoder
interface priority_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic         ei;
  logic [N-1:0] i;
  logic         rdy;
  logic [W-1:0] y;
  logic [N-1:0] g;
  logic         vld;
  logic         gs;
  logic         eo;

  modport master (
    output ei, i, rdy,
    input  y, g, vld, gs, eo
  );

  modport slave (
    input  ei, i, rdy,
    output y, g, vld, gs, eo
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// rtl/priority_encoder_rr.sv - registered N-input priority encoder, fixed or round-robin
// Result held under VLD & !RDY; EI low always clears, even mid-stall.
module priority_encoder_rr #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  priority_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] y_q,   y_d;
  logic [N-1:0] g_q,   g_d;
  logic         vld_q, vld_d;
  logic         eo_q,  eo_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] win_fixed;
  logic [W-1:0] win_rr;
  logic [W-1:0] win;
  logic [W:0]   pos_ext;
  logic         any_req;
  logic         adv;

  always_comb begin
    win_fixed = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.i[k]) win_fixed = W'(k);
    end
  end

  // Walk the offsets from farthest to nearest so the nearest set bit below PTR wins.
  always_comb begin
    win_rr  = '0;
    pos_ext = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos_ext = {1'b0, ptr_q} + (W+1)'(N) - (W+1)'(off);
      if (pos_ext >= (W+1)'(N)) pos_ext = pos_ext - (W+1)'(N);
      if (bus.i[pos_ext[W-1:0]]) win_rr = pos_ext[W-1:0];
    end
  end

  assign win     = (MODE == 1) ? win_rr : win_fixed;
  assign any_req = |bus.i;
  assign adv     = !vld_q || bus.rdy;

  always_comb begin
    y_d   = y_q;
    g_d   = g_q;
    vld_d = vld_q;
    eo_d  = eo_q;
    ptr_d = ptr_q;
    if (!bus.ei) begin
      y_d   = '0;
      g_d   = '0;
      vld_d = 1'b0;
      eo_d  = 1'b0;
    end else if (!adv) begin
      y_d   = y_q;
    end else if (!any_req) begin
      y_d   = '0;
      g_d   = '0;
      vld_d = 1'b0;
      eo_d  = 1'b1;
    end else begin
      y_d   = win;
      g_d   = ONE_HOT << win;
      vld_d = 1'b1;
      eo_d  = 1'b0;
      // The line just granted drops to lowest priority for the next search.
      if (MODE == 1) ptr_d = (win == '0) ? LAST : win - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      g_q   <= '0;
      vld_q <= 1'b0;
      eo_q  <= 1'b0;
      ptr_q <= LAST;
    end else begin
      y_q   <= y_d;
      g_q   <= g_d;
      vld_q <= vld_d;
      eo_q  <= eo_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(vld_q && eo_q));
  end

  assign bus.y   = y_q;
  assign bus.g   = g_q;
  assign bus.vld = vld_q;
  assign bus.gs  = vld_q;
  assign bus.eo  = eo_q;
endmodule
